xpb_accum_seq: RTL and testbench
================================

# xpb_accum_seq

Sequencer for the xpb reduction stage of the modular squarer. It accepts one wide upper-word value plus a base value per operation and splits the upper word into NUM_SEG segments of SEG_BITS bits. It issues one lookup per cycle to the shared bank of xpb tables (segment select plus 5-bit index), then accumulates the returned DATA_W-bit values onto the base. The result is a full-width sum for the next carry-propagation stage.

## Interface
Parameters:
- SEG_BITS, 5, index width per segment (matches table address width)
- NUM_SEG, 8, number of segments/tables sequenced per operation
- DATA_W, 1024, table output width
- LAT, 1, cycles from request cycle to table data valid (registered table = 1)
- ACC_W, DATA_W+4, accumulator width; must be ≥ DATA_W+clog2(NUM_SEG+1)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- start  input  1  request new operation; sampled only in IDLE
- upper_in  input  NUM_SEG*SEG_BITS  segments; segment k = upper_in[k*SEG_BITS +: SEG_BITS]
- base_in  input  DATA_W  initial accumulator value (lower word)
- busy  output  1  high from cycle after accepted start until done cycle inclusive
- xpb_req  output  1  lookup issued this cycle
- xpb_sel  output  clog2(NUM_SEG)  table select for current lookup
- xpb_idx  output  SEG_BITS  table index for current lookup
- xpb_data  input  DATA_W  table result, valid LAT cycles after matching xpb_req
- sum_out  output  ACC_W  accumulated result, held stable from done until next accepted start
- done  output  1  one-cycle pulse, sum_out final

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, capture upper_in into segment register. Load acc ← zero-extended base_in. Set seg counter=0. Go to ISSUE.
- ISSUE: drive xpb_req=1, xpb_sel=counter, xpb_idx=segment[counter]. Increment the counter. After segment NUM_SEG-1, go to DRAIN.
- Every segment is issued, including index 0 (table returns 0). Latency is fixed and data-independent.
- Valid tracking: LAT-deep shift register of xpb_req. When its tail is 1, acc ← acc + zero-extend(xpb_data) at the end of that cycle.
- DRAIN: wait until the last in-flight accumulation completes, then go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Arithmetic: plain unsigned add at ACC_W; no modular wrap. Sizing rule guarantees no overflow: max (NUM_SEG+1)·(2^DATA_W−1).
- start while busy: ignored; no queuing. The captured operands are unaffected by input changes after acceptance.
- start in DONE cycle: ignored; accepted earliest in the following IDLE cycle.
- Reset (any state, including mid-operation): state→IDLE and valid pipe cleared, so in-flight table data is discarded. acc cleared to 0.

## Timing
- Reset values: busy=0, xpb_req=0, xpb_sel=0, xpb_idx=0, sum_out=0, done=0.
- xpb_req/xpb_sel/xpb_idx are registered outputs.
- Cycle 0: start sampled high in IDLE.
- Cycles 1..NUM_SEG: xpb_req=1, with segment k presented in cycle 1+k.
- Data for segment k is valid in cycle 1+k+LAT and is accumulated at the end of that cycle.
- Last accumulation: end of cycle NUM_SEG+LAT. done=1 in cycle NUM_SEG+LAT+1; defaults give cycle 10.
- Back-to-back: next start is accepted in cycle NUM_SEG+LAT+2 at the earliest, giving throughput of one operation per NUM_SEG+LAT+2 cycles.
- xpb_req=0 in all non-ISSUE cycles; xpb_sel/xpb_idx hold their last value.

## Test plan
Bench table model: xpb_data = zero-extended {sel,idx}, registered (LAT=1), unless stated otherwise.
- Zero operation: after reset, start with upper_in=0 and base_in=0. Requires xpb_req high in cycles 1–8 with sel 0..7 and idx 0, done in cycle 10, sum_out=0x0.
- Single segment: upper_in with segment 3 = 5'h11, others 0, base_in=0x100. Requires sum_out = 0x100 + {3,5'h11} = 0x100+0x71 = 0x171, done in cycle 10.
- Saturation/width: model returns 2^1024−1 for every request, base_in = 2^1024−1, upper_in all ones. Requires sum_out = 9·(2^1024−1) exactly, with bit 1027..1024 = 4'h8 and no truncation.
- Start while busy: a second start pulse in cycles 3 and 10 with different operands. Requires both to be ignored, sum_out to reflect the first operands only, and no extra xpb_req.
- Reset mid-operation: assert reset in cycle 5 for one cycle. Requires all outputs at reset values the next cycle and no done. A new start afterwards completes with correct sum and done exactly 10 cycles after acceptance.
- Back-to-back with LAT=2: two operations, second start held high. Requires the second to be accepted in the cycle after done, done spacing 12 cycles, and both sums correct.

Source files
------------

// File: rtl/xpb_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_accum_seq
//  Purpose  : Sequencer for the xpb reduction stage of the modular squarer.
//             Splits a wide upper word into NUM_SEG segments of SEG_BITS bits,
//             issues one table lookup per cycle to the shared xpb table bank,
//             and accumulates the returned values onto a base (lower word).
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             start           - begin an operation (honoured only when idle)
//             upper_in        - packed segments, seg k = [k*SEG_BITS +: SEG_BITS]
//             base_in         - initial accumulator value
//             busy            - operation in progress (through the done cycle)
//             xpb_req/sel/idx - registered lookup request to the table bank
//             xpb_data        - table result, valid LAT cycles after a request
//             sum_out         - accumulated result, stable after done
//             done            - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module xpb_accum_seq #(
    parameter int SEG_BITS = 5,
    parameter int NUM_SEG  = 8,
    parameter int DATA_W   = 1024,
    parameter int LAT      = 1,
    parameter int ACC_W    = DATA_W + 4,
    localparam int c_SEL_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NUM_SEG*SEG_BITS-1:0]  upper_in,
    input  logic [DATA_W-1:0]            base_in,
    output logic                         busy,
    output logic                         xpb_req,
    output logic [c_SEL_W-1:0]           xpb_sel,
    output logic [SEG_BITS-1:0]          xpb_idx,
    input  logic [DATA_W-1:0]            xpb_data,
    output logic [ACC_W-1:0]             sum_out,
    output logic                         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Tail position of the valid pipe: the stage whose data is consumed now.
    localparam logic [LAT-1:0] c_TAIL = LAT'(1) << (LAT - 1);

    state_t               r_state;
    logic [SEG_BITS-1:0]  r_seg [NUM_SEG];
    logic [LAT-1:0]       r_vpipe;
    logic [ACC_W-1:0]     r_acc;
    logic                 r_busy;
    logic                 r_req;
    logic [c_SEL_W-1:0]   r_sel;
    logic [SEG_BITS-1:0]  r_idx;
    logic                 r_done;

    logic [c_SEL_W-1:0]   w_next_sel;
    logic                 w_last;
    logic                 w_inflight;

    assign w_next_sel = r_sel + 1'b1;
    assign w_last     = (r_sel == c_SEL_W'(NUM_SEG - 1));
    // Requests still travelling towards the tail; the tail itself is being
    // accumulated this cycle, so it does not hold up completion.
    assign w_inflight = |(r_vpipe & ~c_TAIL);

    // Operand capture: only loaded on acceptance, so later input changes
    // cannot disturb an operation in progress.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start && !reset) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                r_seg[k] <= upper_in[k*SEG_BITS +: SEG_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_vpipe <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_req   <= 1'b0;
            r_sel   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            // Valid tracking mirrors the table latency.
            r_vpipe[0] <= r_req;
            for (int i = 1; i < LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end

            if (r_vpipe[LAT-1]) begin
                r_acc <= r_acc + ACC_W'(xpb_data);
            end

            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Pipe is empty in IDLE, so this load never races an add.
                        r_acc   <= ACC_W'(base_in);
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_sel   <= '0;
                        r_idx   <= upper_in[SEG_BITS-1:0];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_last) begin
                        r_req   <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_sel <= w_next_sel;
                        r_idx <= r_seg[w_next_sel];
                    end
                end
                S_DRAIN: begin
                    if (!w_inflight) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy    = r_busy;
    assign xpb_req = r_req;
    assign xpb_sel = r_sel;
    assign xpb_idx = r_idx;
    assign sum_out = r_acc;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_xpb_accum_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xpb_accum_seq
//  Purpose  : Self-checking bench for xpb_accum_seq (LAT=1 and LAT=2 copies)
//             with a behavioural xpb table and an expected-sum scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xpb_accum_seq;

    localparam int SB = 5;
    localparam int NS = 8;
    localparam int DW = 1024;
    localparam int AW = DW + 4;
    localparam int UW = NS * SB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start1, start2;
    logic [UW-1:0] upper1, upper2;
    logic [DW-1:0] base1, base2;
    logic          busy1, req1, done1, busy2, req2, done2;
    logic [2:0]    sel1, sel2;
    logic [4:0]    idx1, idx2;
    logic [DW-1:0] data1, data2, data2_s1;
    logic [AW-1:0] sum1, sum2;
    bit            sat;

    int n_checks = 0;
    int n_errors = 0;
    logic [AW-1:0] exp_q1[$];
    logic [AW-1:0] exp_q2[$];

    xpb_accum_seq #(.SEG_BITS(SB), .NUM_SEG(NS), .DATA_W(DW), .LAT(1), .ACC_W(AW)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .upper_in(upper1), .base_in(base1),
        .busy(busy1), .xpb_req(req1), .xpb_sel(sel1), .xpb_idx(idx1),
        .xpb_data(data1), .sum_out(sum1), .done(done1)
    );

    xpb_accum_seq #(.SEG_BITS(SB), .NUM_SEG(NS), .DATA_W(DW), .LAT(2), .ACC_W(AW)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .upper_in(upper2), .base_in(base2),
        .busy(busy2), .xpb_req(req2), .xpb_sel(sel2), .xpb_idx(idx2),
        .xpb_data(data2), .sum_out(sum2), .done(done2)
    );

    // Table model: index 0 reads as zero, otherwise {sel,idx}; sat forces all ones.
    function automatic logic [DW-1:0] tbl(input logic [2:0] s, input logic [4:0] i, input bit sa);
        if (sa) return '1;
        if (i == 5'd0) return '0;
        return {{(DW-8){1'b0}}, s, i};
    endfunction

    function automatic logic [AW-1:0] model_sum(input logic [UW-1:0] up, input logic [DW-1:0] base);
        logic [AW-1:0] acc;
        acc = AW'(base);
        for (int k = 0; k < NS; k++) acc += AW'(tbl(3'(k), up[k*SB +: SB], 1'b0));
        return acc;
    endfunction

    // Registered tables: one stage for LAT=1, two stages for LAT=2.
    always @(posedge clk) begin
        data1    <= tbl(sel1, idx1, sat);
        data2_s1 <= tbl(sel2, idx2, sat);
        data2    <= data2_s1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sum(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        logic [1279:0] o, e;
        o = 1280'(obs);
        e = 1280'(exp);
        for (int i = 0; i < 5; i++) chk($sformatf("%s[%0d]", tag, i), o[i*256 +: 256], e[i*256 +: 256]);
    endtask

    // One LAT=1 operation started in the current cycle (cycle 0); checks the
    // request stream, busy/done timing and the popped scoreboard sum.
    task automatic run_op1(input string tag, input logic [UW-1:0] up, input logic [DW-1:0] base,
                           input logic [AW-1:0] exp, input bit poke);
        int ndone;
        ndone  = 0;
        start1 = 1'b1;
        upper1 = up;
        base1  = base;
        exp_q1.push_back(exp);
        @(posedge clk); #1;
        upper1 = ~up;
        base1  = ~base;
        for (int c = 1; c <= 11; c++) begin
            start1 = poke && (c == 3 || c == 10);
            @(negedge clk);
            chk($sformatf("%s_req_c%0d", tag, c), req1, (c <= 8));
            if (c <= 8) begin
                chk($sformatf("%s_sel_c%0d", tag, c), sel1, c - 1);
                chk($sformatf("%s_idx_c%0d", tag, c), idx1, up[(c-1)*SB +: SB]);
            end
            chk($sformatf("%s_busy_c%0d", tag, c), busy1, (c <= 10));
            chk($sformatf("%s_done_c%0d", tag, c), done1, (c == 10));
            if (done1 && exp_q1.size() > 0) begin
                ndone++;
                chk_sum({tag, "_sum"}, sum1, exp_q1.pop_front());
            end
            @(posedge clk); #1;
        end
        start1 = 1'b0;
        chk({tag, "_ndone"}, ndone, 1);
        exp_q1.delete();
    endtask

    initial begin
        int first, second, ndone2;
        logic [UW-1:0] ua, ub;
        logic [DW-1:0] ba, bb;
        logic [AW-1:0] sat_exp;

        reset = 1'b1; sat = 1'b0;
        start1 = 1'b0; upper1 = '0; base1 = '0;
        start2 = 1'b0; upper2 = '0; base2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_req", req1, 0);
        chk("rst_sel", sel1, 0);
        chk("rst_idx", idx1, 0);
        chk("rst_done", done1, 0);
        chk_sum("rst_sum", sum1, '0);
        chk("rst_busy2", busy2, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Zero operation
        run_op1("zero", '0, '0, '0, 1'b0);

        // Single segment: segment 3 = 0x11 over base 0x100
        run_op1("single", UW'(5'h11) << (3*SB), DW'(12'h100), AW'(12'h171), 1'b0);

        // Mixed segments, including index-0 slots
        run_op1("mixed", 40'hA5_00_3C_C3_96, DW'(64'hDEAD_BEEF_0123_4567),
                model_sum(40'hA5_00_3C_C3_96, DW'(64'hDEAD_BEEF_0123_4567)), 1'b0);

        // Start pulses in cycle 3 and in the done cycle must be ignored
        run_op1("busy_start", 40'h01_23_45_67_89, DW'(32'h55AA),
                model_sum(40'h01_23_45_67_89, DW'(32'h55AA)), 1'b1);

        // Saturation: 9 * (2^1024 - 1) with no truncation
        sat = 1'b1;
        sat_exp = AW'({DW{1'b1}}) * AW'(9);
        run_op1("sat", '1, '1, sat_exp, 1'b0);
        chk("sat_top", sum1[AW-1:DW], 4'h8);
        sat = 1'b0;

        // Reset in cycle 5 of an operation
        start1 = 1'b1; upper1 = 40'h1F_1F_1F_1F_1F; base1 = DW'(16'h7777);
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_req", req1, 0);
        chk("mid_rst_sel", sel1, 0);
        chk("mid_rst_idx", idx1, 0);
        chk("mid_rst_done", done1, 0);
        chk_sum("mid_rst_sum", sum1, '0);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); @(negedge clk);
            chk($sformatf("mid_rst_nodone_%0d", c), done1, 0);
        end
        @(posedge clk); #1;
        run_op1("after_rst", 40'h10_08_04_02_01, DW'(20'hABCDE),
                model_sum(40'h10_08_04_02_01, DW'(20'hABCDE)), 1'b0);

        // Back-to-back on LAT=2 with start held high
        ua = 40'h3E_21_00_14_0F; ba = DW'(24'h123456);
        ub = 40'h05_1B_19_02_1F; bb = DW'(24'hFEDCBA);
        exp_q2.push_back(model_sum(ua, ba));
        exp_q2.push_back(model_sum(ub, bb));
        start2 = 1'b1; upper2 = ua; base2 = ba;
        @(posedge clk); #1;
        upper2 = ub; base2 = bb;
        first = -1; second = -1; ndone2 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 12) chk("b2b_idle_c12", busy2, 0);
            if (c == 13) begin
                chk("b2b_req_c13", req2, 1);
                chk("b2b_idx_c13", idx2, ub[SB-1:0]);
            end
            if (done2) begin
                ndone2++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
                if (exp_q2.size() > 0) chk_sum($sformatf("b2b_sum%0d", ndone2), sum2, exp_q2.pop_front());
            end
            @(posedge clk); #1;
            if (c == 12) start2 = 1'b0;
        end
        chk("b2b_ndone", ndone2, 2);
        chk("b2b_first_done", first, 11);
        chk("b2b_second_done", second, 23);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
